sequenciador_de_programa: RTL and testbench

- Parametrised successor to the CPU's program counter. Produces the instruction fetch address each cycle.
- Supports sequential advance, hold, signed relative branch, conditional branch, absolute jump, and return to an address taken from the T bus.
- Adds an internal hardware return-address stack for CALL/RET, with full/empty status and sticky fault flags.
- Sits between the instruction decoder and the instruction memory address port.

---
 rtl/sequenciador_de_programa.sv | 111 +++++++++++
 tb/tb_sequenciador_de_programa.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_de_programa.sv
// Program sequencer: produces the fetch address each cycle and keeps a hardware
// return-address stack for CALL/RET, with sticky overflow/underflow flags.
module sequenciador_de_programa #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 11,
  parameter int STACK_DEPTH  = 16,
  parameter int RESET_ADDR   = 0,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              op,
  input  logic                    cond,
  input  logic                    halt,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [ADDR_WIDTH-1:0]   target,
  input  logic [ADDR_WIDTH-1:0]   Tbus,
  input  logic                    clear_fault,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic [DEPTH_W-1:0]      rs_depth,
  output logic                    rs_full,
  output logic                    rs_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT  = 3'b000,
    OP_HOLD  = 3'b001,
    OP_BR    = 3'b010,
    OP_BRZ   = 3'b011,
    OP_JMP   = 3'b100,
    OP_CALL  = 3'b101,
    OP_RET   = 3'b110,
    OP_RET_T = 3'b111
  } op_e;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [DEPTH_W-1:0]    depth;
  logic [DEPTH_W-1:0]    depth_dec;
  logic [PTR_W-1:0]      push_idx;
  logic [PTR_W-1:0]      top_idx;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_rel;
  logic [ADDR_WIDTH-1:0] off_ext;
  logic                  do_push;

  assign off_ext   = ADDR_WIDTH'($signed(offset));
  assign pc_inc    = pc + ADDR_WIDTH'(1);
  assign pc_rel    = pc + off_ext;
  assign depth_dec = depth - DEPTH_W'(1);
  // Index slices are only used when depth is in range (push when not full, pop when not empty).
  assign push_idx  = depth[PTR_W-1:0];
  assign top_idx   = depth_dec[PTR_W-1:0];

  assign rs_depth = depth;
  assign rs_full  = (depth == DEPTH_W'(STACK_DEPTH));
  assign rs_empty = (depth == '0);

  assign do_push = !halt && (op_e'(op) == OP_CALL) && !rs_full;

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (do_push) stack_mem[push_idx] <= pc_inc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= ADDR_WIDTH'(RESET_ADDR);
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clear_fault) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      // Fault assignments below come after the clear so a same-cycle fault wins.
      if (!halt) begin
        case (op_e'(op))
          OP_NEXT:  pc <= pc_inc;
          OP_HOLD:  pc <= pc;
          OP_BR:    pc <= pc_rel;
          OP_BRZ:   pc <= cond ? pc_rel : pc_inc;
          OP_JMP:   pc <= target;
          OP_CALL: begin
            if (rs_full) begin
              overflow <= 1'b1;
            end else begin
              pc    <= target;
              depth <= depth + DEPTH_W'(1);
            end
          end
          OP_RET: begin
            if (rs_empty) begin
              underflow <= 1'b1;
            end else begin
              pc    <= stack_mem[top_idx];
              depth <= depth_dec;
            end
          end
          OP_RET_T: pc <= Tbus;
          default:  pc <= pc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_de_programa.sv
// Directed bench for the program sequencer: branches, wrap, call stack, faults, halt.
module tb_sequenciador_de_programa;

  localparam int AW = 16;
  localparam int OW = 11;
  localparam int SD = 16;
  localparam int DW = $clog2(SD + 1);

  localparam logic [2:0] NEXT = 3'b000, HOLD = 3'b001, BR = 3'b010, BRZ = 3'b011,
                         JMP = 3'b100, CALL = 3'b101, RET = 3'b110, RET_T = 3'b111;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    op = NEXT;
  logic          cond = 1'b0;
  logic          halt = 1'b0;
  logic [OW-1:0] offset = '0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] Tbus = '0;
  logic          clear_fault = 1'b0;
  logic [AW-1:0] pc;
  logic [DW-1:0] rs_depth;
  logic          rs_full, rs_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sequenciador_de_programa #(
    .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .STACK_DEPTH(SD), .RESET_ADDR(0)
  ) dut (
    .clock(clock), .reset(reset), .op(op), .cond(cond), .halt(halt),
    .offset(offset), .target(target), .Tbus(Tbus), .clear_fault(clear_fault),
    .pc(pc), .rs_depth(rs_depth), .rs_full(rs_full), .rs_empty(rs_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // Apply op for one edge; returns 1 time unit after the edge.
  task automatic cyc(input logic [2:0] o);
    op = o;
    @(posedge clock);
    #1;
  endtask

  task automatic jump_to(input logic [AW-1:0] a);
    target = a;
    cyc(JMP);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
    checks++; if (rs_depth !== 5'd0 || rs_empty !== 1'b1 || rs_full !== 1'b0) begin
      errors++; $display("FAIL reset_stack: depth=%0d empty=%b full=%b want 0/1/0", rs_depth, rs_empty, rs_full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ov=%b un=%b want 0/0", overflow, underflow); end
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(NEXT);
      checks++; if (pc !== AW'(i)) begin errors++; $display("FAIL next_seq: got %h want %h", pc, AW'(i)); end
    end
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL next_empty: got %b want 1", rs_empty); end
    jump_to(16'h0003);
    #2 reset = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_reset: got %h want 0000", pc); end
    #1 reset = 1'b1;
    cyc(NEXT);
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL after_reset_next: got %h want 0001", pc); end
  endtask

  task automatic test_branch;
    jump_to(16'h0010);
    offset = 11'h7FC; cyc(BR);
    checks++; if (pc !== 16'h000C) begin errors++; $display("FAIL br_neg: got %h want 000c", pc); end
    jump_to(16'h0002);
    cyc(BR);
    checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL br_wrap: got %h want fffe", pc); end
    jump_to(16'hFFF0);
    offset = 11'h3FF; cyc(BR);
    checks++; if (pc !== 16'h03EF) begin errors++; $display("FAIL br_pos_wrap: got %h want 03ef", pc); end
    jump_to(16'hFFFF);
    cyc(NEXT);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL next_wrap: got %h want 0000", pc); end
  endtask

  task automatic test_brz_jmp_rett;
    offset = 11'd8;
    jump_to(16'h0020);
    cond = 1'b1; cyc(BRZ);
    checks++; if (pc !== 16'h0028) begin errors++; $display("FAIL brz_taken: got %h want 0028", pc); end
    jump_to(16'h0020);
    cond = 1'b0; cyc(BRZ);
    checks++; if (pc !== 16'h0021) begin errors++; $display("FAIL brz_not_taken: got %h want 0021", pc); end
    jump_to(16'h1234);
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL jmp: got %h want 1234", pc); end
    cyc(HOLD);
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL hold: got %h want 1234", pc); end
    Tbus = 16'h0ABC; cyc(RET_T);
    checks++; if (pc !== 16'h0ABC || rs_depth !== 5'd0) begin
      errors++; $display("FAIL ret_t: pc=%h depth=%0d want 0abc/0", pc, rs_depth); end
  endtask

  task automatic test_calls;
    jump_to(16'h0010);
    target = 16'h0100; cyc(CALL);
    checks++; if (pc !== 16'h0100 || rs_depth !== 5'd1) begin
      errors++; $display("FAIL call1: pc=%h depth=%0d want 0100/1", pc, rs_depth); end
    target = 16'h0200; cyc(CALL);
    checks++; if (pc !== 16'h0200 || rs_depth !== 5'd2) begin
      errors++; $display("FAIL call2: pc=%h depth=%0d want 0200/2", pc, rs_depth); end
    Tbus = 16'h7777; cyc(RET_T);
    checks++; if (pc !== 16'h7777 || rs_depth !== 5'd2) begin
      errors++; $display("FAIL ret_t_keeps_stack: pc=%h depth=%0d want 7777/2", pc, rs_depth); end
    cyc(RET);
    checks++; if (pc !== 16'h0101 || rs_depth !== 5'd1) begin
      errors++; $display("FAIL ret1: pc=%h depth=%0d want 0101/1", pc, rs_depth); end
    cyc(RET);
    checks++; if (pc !== 16'h0011 || rs_empty !== 1'b1) begin
      errors++; $display("FAIL ret2: pc=%h empty=%b want 0011/1", pc, rs_empty); end
  endtask

  task automatic test_back_to_back;
    jump_to(16'h0040);
    target = 16'h0300; cyc(CALL);
    cyc(RET);
    checks++; if (pc !== 16'h0041) begin errors++; $display("FAIL b2b_ret1: got %h want 0041", pc); end
    target = 16'h0500; cyc(CALL);
    checks++; if (pc !== 16'h0500) begin errors++; $display("FAIL b2b_call2: got %h want 0500", pc); end
    cyc(RET);
    checks++; if (pc !== 16'h0042 || rs_depth !== 5'd0) begin
      errors++; $display("FAIL b2b_ret2: pc=%h depth=%0d want 0042/0", pc, rs_depth); end
    jump_to(16'hFFFF);
    target = 16'h0050; cyc(CALL);
    cyc(RET);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL ret_addr_wrap: got %h want 0000", pc); end
  endtask

  task automatic test_overflow_underflow;
    logic [AW-1:0] exp_stack [$];
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] want;
    exp_pc = 16'h1000;
    jump_to(exp_pc);
    for (int i = 0; i < SD; i++) begin
      exp_stack.push_back(exp_pc + 16'd1);
      exp_pc = 16'h2000 + AW'(i * 16);
      target = exp_pc; cyc(CALL);
      checks++; if (pc !== exp_pc || rs_depth !== DW'(i + 1)) begin
        errors++; $display("FAIL fill_call%0d: pc=%h depth=%0d want %h/%0d", i, pc, rs_depth, exp_pc, i + 1); end
    end
    checks++; if (rs_full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL full: full=%b ov=%b want 1/0", rs_full, overflow); end
    target = 16'h9999; cyc(CALL);
    checks++; if (pc !== exp_pc || overflow !== 1'b1 || rs_depth !== 5'd16) begin
      errors++; $display("FAIL overflow: pc=%h ov=%b depth=%0d want %h/1/16", pc, overflow, rs_depth, exp_pc); end
    for (int i = 0; i < SD; i++) begin
      cyc(RET);
      want = exp_stack.pop_back();
      exp_pc = want;
      checks++; if (pc !== want) begin errors++; $display("FAIL lifo_ret%0d: got %h want %h", i, pc, want); end
    end
    checks++; if (rs_empty !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL drained: empty=%b un=%b ov=%b want 1/0/1", rs_empty, underflow, overflow); end
    cyc(RET);
    checks++; if (pc !== exp_pc || underflow !== 1'b1) begin
      errors++; $display("FAIL underflow: pc=%h un=%b want %h/1", pc, underflow, exp_pc); end
    clear_fault = 1'b1; cyc(HOLD); clear_fault = 1'b0;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL clear_fault: ov=%b un=%b want 0/0", overflow, underflow); end
    clear_fault = 1'b1; cyc(RET); clear_fault = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL fault_beats_clear: un=%b want 1", underflow); end
    cyc(HOLD);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL flag_sticky: un=%b want 1", underflow); end
  endtask

  task automatic test_halt;
    jump_to(16'h0060);
    halt = 1'b1; target = 16'h0700;
    for (int i = 0; i < 3; i++) begin
      cyc(CALL);
      checks++; if (pc !== 16'h0060 || rs_depth !== 5'd0) begin
        errors++; $display("FAIL halt_hold%0d: pc=%h depth=%0d want 0060/0", i, pc, rs_depth); end
    end
    clear_fault = 1'b1; cyc(RET); clear_fault = 1'b0;
    checks++; if (underflow !== 1'b0 || pc !== 16'h0060) begin
      errors++; $display("FAIL halt_clear: un=%b pc=%h want 0/0060", underflow, pc); end
    halt = 1'b0;
    cyc(CALL);
    checks++; if (pc !== 16'h0700 || rs_depth !== 5'd1) begin
      errors++; $display("FAIL halt_release: pc=%h depth=%0d want 0700/1", pc, rs_depth); end
    cyc(RET);
    checks++; if (pc !== 16'h0061 || rs_depth !== 5'd0) begin
      errors++; $display("FAIL halt_ret: pc=%h depth=%0d want 0061/0", pc, rs_depth); end
  endtask

  initial begin
    #2;
    test_reset();
    test_branch();
    test_brz_jmp_rett();
    test_calls();
    test_back_to_back();
    test_overflow_underflow();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
